// File: rtl/square_pad_writer.sv
// -----------------------------------------------------------------------------
// square_pad_writer
//
// Producer side of the padded-square mask buffer read by the detection overlay
// stage.  A raster pixel stream of width x height is rewritten as a
// size x size square, where size = max(height, width) after each is rounded
// up to a multiple of 8.  Padding positions are written as zero.  Each square
// position becomes one word write at address row*size + col.  The address is
// produced by an incrementing counter, so no multiplier is needed.
//
// Ports
//   clk       : clock, all logic on the rising edge
//   reset     : synchronous, active-high; aborts any frame immediately
//   start     : begin a frame (only looked at in IDLE)
//   width     : source columns, captured when start is accepted
//   height    : source rows, captured when start is accepted
//   in_valid  : in_data carries the next source pixel (raster order)
//   in_ready  : block takes the pixel on this cycle if in_valid is also high
//   in_data   : source pixel
//   wr_en     : registered memory write strobe
//   wr_addr   : registered memory write address
//   wr_data   : registered memory write data
//   size_out  : square side computed in CALC, held until the next frame
//   busy      : high in CALC and FILL
//   done      : one-cycle end-of-frame pulse, the cycle after the last write
//   err       : high together with done when the frame was rejected
//
// Handshake: a source pixel is consumed on a rising edge where both in_valid
// and in_ready are high.  in_ready depends only on internal state (never on
// in_valid), is high only at source positions in FILL, and stays high while
// the producer withholds a pixel.  Pad positions never raise in_ready, so
// surplus pixels offered by the producer are never taken.
//
// The FSM state is kept in the signal "state" (type state_t) so that bound
// checkers can observe it directly.
// -----------------------------------------------------------------------------
module square_pad_writer #(
  parameter int DATA_W = 32,
  parameter int DIM_W  = 16,
  parameter int ADDR_W = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [DIM_W-1:0]  width,
  input  logic [DIM_W-1:0]  height,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [DATA_W-1:0] wr_data,
  output logic [DIM_W-1:0]  size_out,
  output logic              busy,
  output logic              done,
  output logic              err
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } state_t;

  // One extra bit so rounding a width close to 2**DIM_W cannot wrap to zero.
  localparam int RW = DIM_W + 1;
  localparam logic [2*RW-1:0] AREA_LIMIT = (2*RW)'(1) << ADDR_W;

  state_t state;
  state_t state_next;

  logic [DIM_W-1:0]  width_q;
  logic [DIM_W-1:0]  height_q;
  logic [DIM_W-1:0]  row;
  logic [DIM_W-1:0]  col;
  logic [ADDR_W-1:0] addr;
  logic              err_q;

  logic [RW-1:0]     w8;
  logic [RW-1:0]     h8;
  logic [RW-1:0]     size_calc;
  logic [2*RW-1:0]   area;
  logic              calc_bad;

  logic              is_src;
  logic              fire;
  logic              row_end;
  logic              last_pos;

  // Square geometry from the captured dimensions (used in CALC).
  always_comb begin
    w8        = ({1'b0, width_q}  + RW'(7)) & ~RW'(7);
    h8        = ({1'b0, height_q} + RW'(7)) & ~RW'(7);
    size_calc = (h8 > w8) ? h8 : w8;
    // Full-width product so the limit compare happens before any truncation.
    area      = {{RW{1'b0}}, size_calc} * {{RW{1'b0}}, size_calc};
    calc_bad  = (width_q == '0) || (height_q == '0) || (area > AREA_LIMIT);
  end

  // Scan position decode for FILL.
  always_comb begin
    is_src   = (row < height_q) && (col < width_q);
    // Pad positions always advance; source positions wait for a pixel.
    fire     = (state == FILL) && (!is_src || in_valid);
    row_end  = (col == size_out - DIM_W'(1));
    last_pos = row_end && (row == size_out - DIM_W'(1));
  end

  // FSM: next state and combinational outputs.
  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    busy       = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_next = CALC;
      end
      CALC: begin
        busy       = 1'b1;
        state_next = calc_bad ? DONE : FILL;
      end
      FILL: begin
        busy     = 1'b1;
        in_ready = is_src;
        if (fire && last_pos) state_next = DONE;
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Datapath: captured dimensions, scan counters and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      width_q  <= '0;
      height_q <= '0;
      row      <= '0;
      col      <= '0;
      addr     <= '0;
      err_q    <= 1'b0;
      size_out <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      wr_en <= 1'b0;
      // done/err are registered from the DONE state so the pulse lands on
      // the cycle after the final registered write.
      done  <= (state == DONE);
      err   <= (state == DONE) && err_q;
      case (state)
        IDLE: begin
          if (start) begin
            width_q  <= width;
            height_q <= height;
          end
        end
        CALC: begin
          size_out <= size_calc[DIM_W-1:0];
          err_q    <= calc_bad;
          row      <= '0;
          col      <= '0;
          addr     <= '0;
        end
        FILL: begin
          if (fire) begin
            wr_en   <= 1'b1;
            wr_addr <= addr;
            wr_data <= is_src ? in_data : '0;
            addr    <= addr + ADDR_W'(1);
            if (row_end) begin
              col <= '0;
              row <= row + DIM_W'(1);
            end else begin
              col <= col + DIM_W'(1);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
